// File: rtl/collision_scorer_pkg.sv
// Shared constants, state codes and BCD helper for the collision/score block.
package collision_scorer_pkg;

    localparam int N_PIPE    = 3;
    localparam int BIRD_W    = 5;
    localparam int PIPE_HALF = 2;
    localparam int GRACE     = 4;
    localparam int ORIG      = 16;
    localparam int GAP_LEN   = 10;

    localparam int PIPE_W  = 24;
    localparam int POS_LSB = 16;
    localparam int MAX_LSB = 8;
    localparam int MIN_LSB = 0;

    // Furthest pipe position (relative to ORIG) that still touches the bird.
    localparam int HIT_REACH = BIRD_W - 1 + PIPE_HALF;

    typedef enum logic [1:0] {
        SCENE_SPLASH   = 2'd0,
        SCENE_PLAYING  = 2'd1,
        SCENE_GAMEOVER = 2'd2
    } scene_t;

    typedef enum logic [1:0] {
        CS_IDLE  = 2'd0,
        CS_ARMED = 2'd1,
        CS_LIVE  = 2'd2,
        CS_DEAD  = 2'd3
    } cs_state_t;

    // Adds one to a 4-digit BCD value, holding at 9999.
    function automatic logic [15:0] bcd_inc_sat(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        logic [3:0]  dig;
        r     = v;
        carry = 1'b1;
        if (v != 16'h9999) begin
            for (int d = 0; d < 4; d++) begin
                dig = r[4*d +: 4];
                if (carry) begin
                    if (dig == 4'd9) begin
                        dig = 4'd0;
                    end else begin
                        dig   = dig + 4'd1;
                        carry = 1'b0;
                    end
                end
                r[4*d +: 4] = dig;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/collision_scorer_if.sv
// Bus between controller/view and the collision scorer.
interface collision_scorer_if;
    import collision_scorer_pkg::*;

    logic                     playing;
    logic [7:0]               altitude;
    logic [7:0]               n_row;
    logic [PIPE_W*N_PIPE-1:0] pipes;
    logic                     hit;
    logic                     score_inc;
    logic [15:0]              score_bcd;
    logic [15:0]              best_bcd;
    logic [1:0]               state;

    modport master (
        output playing, altitude, n_row, pipes,
        input  hit, score_inc, score_bcd, best_bcd, state
    );

    modport slave (
        input  playing, altitude, n_row, pipes,
        output hit, score_inc, score_bcd, best_bcd, state
    );

endinterface

// File: rtl/collision_scorer_bcd_counter4.sv
// Four-digit BCD counter with clear, increment and saturation at 9999.
module bcd_counter4
    import collision_scorer_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        inc,
    output logic [15:0] value
);

    // Clear wins over increment; increment stops at 9999.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value <= 16'h0000;
        end else if (clr) begin
            value <= 16'h0000;
        end else if (inc) begin
            value <= bcd_inc_sat(value);
        end
    end

endmodule

// File: rtl/collision_scorer.sv
// Detects bird/pipe/floor/ceiling collisions and keeps the BCD score and best score.
module collision_scorer
    import collision_scorer_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    collision_scorer_if.slave  bus
);

    cs_state_t   state_q;
    logic        hit_q;
    logic        score_inc_q;
    logic [15:0] best_q;
    logic [15:0] score_q;
    logic [7:0]  prev_pos;
    logic [7:0]  grace_cnt;

    logic [7:0]  front_pos;
    logic        collision;
    logic        score_event;
    logic        score_clr;
    logic        score_en;

    assign front_pos   = bus.pipes[POS_LSB +: 8];
    assign score_event = (prev_pos != 8'd0) && (front_pos == 8'd0);
    assign score_clr   = bus.playing && (state_q == CS_IDLE);
    assign score_en    = bus.playing && score_event &&
                         ((state_q == CS_ARMED) || ((state_q == CS_LIVE) && !collision));

    // Collision: floor, ceiling (or wrapped negative y), or a touching pipe whose gap misses the bird.
    always_comb begin
        logic [7:0] p;
        logic [7:0] mx;
        logic [7:0] mn;
        collision = (bus.altitude == 8'd0) || (bus.altitude >= bus.n_row);
        for (int k = 0; k < N_PIPE; k++) begin
            p  = bus.pipes[PIPE_W*k + POS_LSB +: 8];
            mx = bus.pipes[PIPE_W*k + MAX_LSB +: 8];
            mn = bus.pipes[PIPE_W*k + MIN_LSB +: 8];
            if (({1'b0, p} <= 9'(HIT_REACH)) && !((mn < bus.altitude) && (bus.altitude < mx))) begin
                collision = 1'b1;
            end
        end
    end

    bcd_counter4 u_score (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (score_clr),
        .inc   (score_en),
        .value (score_q)
    );

    // Game FSM with registered hit, score pulse and best-score tracking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= CS_IDLE;
            hit_q       <= 1'b0;
            score_inc_q <= 1'b0;
            best_q      <= 16'h0000;
            prev_pos    <= 8'd0;
            grace_cnt   <= 8'd0;
        end else begin
            prev_pos    <= front_pos;
            score_inc_q <= score_en;
            if (!bus.playing) begin
                if (((state_q == CS_ARMED) || (state_q == CS_LIVE)) && (score_q > best_q)) begin
                    best_q <= score_q;
                end
                state_q <= CS_IDLE;
                hit_q   <= 1'b0;
            end else begin
                case (state_q)
                    CS_IDLE: begin
                        grace_cnt <= 8'(GRACE);
                        state_q   <= (GRACE == 0) ? CS_LIVE : CS_ARMED;
                    end
                    CS_ARMED: begin
                        grace_cnt <= grace_cnt - 8'd1;
                        if (grace_cnt <= 8'd1) begin
                            state_q <= CS_LIVE;
                        end
                    end
                    CS_LIVE: begin
                        if (collision) begin
                            state_q <= CS_DEAD;
                            hit_q   <= 1'b1;
                            if (score_q > best_q) begin
                                best_q <= score_q;
                            end
                        end
                    end
                    CS_DEAD: begin
                        hit_q <= 1'b1;
                    end
                    default: begin
                        state_q <= CS_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.hit       = hit_q;
    assign bus.score_inc = score_inc_q;
    assign bus.score_bcd = score_q;
    assign bus.best_bcd  = best_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_collision_scorer.sv
// Bench for collision_scorer: directed game scenarios plus random play against an integer model.
module tb_collision_scorer;
    import collision_scorer_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    collision_scorer_if bus();

    collision_scorer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checkCount = 0;
    int failCount  = 0;
    bit compareOn  = 1'b0;

    // Reference model state: plain integers, score kept in binary.
    int mState = 0;
    int mGrace = 0;
    int mScore = 0;
    int mBest  = 0;
    int mPrev  = 0;
    bit mHit   = 1'b0;
    bit mInc   = 1'b0;
    int mPos0;
    bit mEvent;
    bit mColl;

    function automatic logic [23:0] pipe(input int pos, input int mx, input int mn);
        return {8'(pos), 8'(mx), 8'(mn)};
    endfunction

    function automatic logic [15:0] toBcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic bit modelCollides();
        int a;
        int p;
        int mx;
        int mn;
        a = int'(bus.altitude);
        if (a == 0 || a >= int'(bus.n_row)) return 1'b1;
        for (int k = 0; k < 3; k++) begin
            p  = int'(bus.pipes[24*k + 16 +: 8]);
            mx = int'(bus.pipes[24*k + 8 +: 8]);
            mn = int'(bus.pipes[24*k +: 8]);
            if (p <= 6 && !(mn < a && a < mx)) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s actual=%0h expected=%0h t=%0t", name, actual, expected, $time);
        end
    endtask

    // Model step: game rules applied to the inputs seen at each rising edge.
    always @(posedge clk) begin
        mInc = 1'b0;
        if (!rst_n) begin
            mState = 0; mGrace = 0; mScore = 0; mBest = 0; mPrev = 0; mHit = 1'b0;
        end else begin
            mPos0  = int'(bus.pipes[23:16]);
            mEvent = (mPrev != 0) && (mPos0 == 0);
            mColl  = modelCollides();
            if (!bus.playing) begin
                if ((mState == 1 || mState == 2) && mScore > mBest) mBest = mScore;
                mState = 0;
                mHit   = 1'b0;
            end else begin
                case (mState)
                    0: begin mState = 1; mScore = 0; mGrace = 4; end
                    1: begin
                        if (mEvent) begin mInc = 1'b1; if (mScore < 9999) mScore++; end
                        mGrace--;
                        if (mGrace == 0) mState = 2;
                    end
                    2: begin
                        if (mColl) begin
                            mState = 3; mHit = 1'b1;
                            if (mScore > mBest) mBest = mScore;
                        end else if (mEvent) begin
                            mInc = 1'b1; if (mScore < 9999) mScore++;
                        end
                    end
                    default: ;
                endcase
            end
            mPrev = mPos0;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (compareOn) begin
            checkOutput("cyc_state", 32'(bus.state), 32'(mState));
            checkOutput("cyc_hit", 32'(bus.hit), 32'(mHit));
            checkOutput("cyc_score_inc", 32'(bus.score_inc), 32'(mInc));
            checkOutput("cyc_score", 32'(bus.score_bcd), 32'(toBcd(mScore)));
            checkOutput("cyc_best", 32'(bus.best_bcd), 32'(toBcd(mBest)));
        end
    end

    task automatic applyStimulus(input bit pl, input int alt, input logic [23:0] s0, input int cycles);
        bus.playing       = pl;
        bus.altitude      = 8'(alt);
        bus.pipes[23:0]   = s0;
        repeat (cycles) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic startGame();
        applyStimulus(1'b0, 20, pipe(150, 30, 20), 1);
        applyStimulus(1'b1, 20, pipe(150, 30, 20), 5);
        checkOutput("start_live", 32'(bus.state), 32'd2);
    endtask

    task automatic scorePoints(input int n);
        repeat (n) begin
            applyStimulus(1'b1, 20, pipe(50, 30, 10), 1);
            applyStimulus(1'b1, 20, pipe(0, 30, 10), 1);
        end
    endtask

    task automatic collide();
        applyStimulus(1'b1, 20, pipe(6, 35, 25), 1);
    endtask

    int pulses;
    int steps [5] = '{2, 1, 0, 0, 0};
    int mn;

    initial begin
        bus.playing  = 1'b0;
        bus.altitude = 8'd20;
        bus.n_row    = 8'd40;
        bus.pipes    = {pipe(50, 35, 25), pipe(100, 25, 15), pipe(150, 30, 20)};

        rst_n = 1'b0;
        applyStimulus(1'b0, 20, pipe(150, 30, 20), 2);
        compareOn = 1'b1;
        checkOutput("reset_state", 32'(bus.state), 32'd0);
        checkOutput("reset_hit", 32'(bus.hit), 32'd0);
        checkOutput("reset_score", 32'(bus.score_bcd), 32'h0);
        checkOutput("reset_best", 32'(bus.best_bcd), 32'h0);
        rst_n = 1'b1;

        // Arming and grace period.
        applyStimulus(1'b1, 20, pipe(150, 30, 20), 1);
        checkOutput("armed_state", 32'(bus.state), 32'd1);
        applyStimulus(1'b1, 20, pipe(6, 35, 25), 3);
        checkOutput("grace_no_hit", 32'(bus.hit), 32'd0);
        checkOutput("grace_still_armed", 32'(bus.state), 32'd1);
        applyStimulus(1'b1, 20, pipe(150, 30, 20), 1);
        checkOutput("live_after_grace", 32'(bus.state), 32'd2);
        checkOutput("live_score_zero", 32'(bus.score_bcd), 32'h0);

        // One point for a pos run 2,1,0,0,0.
        pulses = 0;
        foreach (steps[i]) begin
            applyStimulus(1'b1, 20, pipe(steps[i], 30, 10), 1);
            pulses += int'(bus.score_inc);
        end
        checkOutput("single_pulse", 32'(pulses), 32'd1);
        checkOutput("score_one", 32'(bus.score_bcd), 32'h0001);
        scorePoints(1);
        checkOutput("score_two", 32'(bus.score_bcd), 32'h0002);

        // Pipe collision, then no scoring while dead.
        collide();
        checkOutput("pipe_hit", 32'(bus.hit), 32'd1);
        checkOutput("pipe_dead", 32'(bus.state), 32'd3);
        checkOutput("best_on_death", 32'(bus.best_bcd), 32'h0002);
        scorePoints(1);
        checkOutput("dead_no_score", 32'(bus.score_bcd), 32'h0002);

        // Floor and ceiling.
        startGame();
        applyStimulus(1'b1, 0, pipe(150, 30, 20), 1);
        checkOutput("floor_hit", 32'(bus.hit), 32'd1);
        startGame();
        applyStimulus(1'b1, 39, pipe(150, 30, 20), 1);
        checkOutput("below_ceiling_ok", 32'(bus.hit), 32'd0);
        applyStimulus(1'b1, 40, pipe(150, 30, 20), 1);
        checkOutput("ceiling_hit", 32'(bus.hit), 32'd1);

        // Strict gap bounds.
        startGame();
        applyStimulus(1'b1, 11, pipe(3, 30, 10), 2);
        checkOutput("gap_inside_ok", 32'(bus.hit), 32'd0);
        applyStimulus(1'b1, 30, pipe(3, 30, 10), 1);
        checkOutput("gap_max_hit", 32'(bus.hit), 32'd1);

        // BCD carry.
        startGame();
        scorePoints(9);
        checkOutput("score_nine", 32'(bus.score_bcd), 32'h0009);
        scorePoints(1);
        checkOutput("score_ten", 32'(bus.score_bcd), 32'h0010);
        checkOutput("model_score_ten", 32'(toBcd(mScore)), 32'h0010);

        // Reset mid-game.
        rst_n = 1'b0;
        applyStimulus(1'b1, 20, pipe(150, 30, 20), 1);
        checkOutput("midreset_state", 32'(bus.state), 32'd0);
        checkOutput("midreset_inc", 32'(bus.score_inc), 32'd0);
        checkOutput("midreset_score", 32'(bus.score_bcd), 32'h0);
        checkOutput("midreset_best", 32'(bus.best_bcd), 32'h0);
        rst_n = 1'b1;

        // Best survives a lower replay.
        startGame();
        scorePoints(3);
        collide();
        startGame();
        scorePoints(1);
        collide();
        checkOutput("best_kept", 32'(bus.best_bcd), 32'h0003);
        checkOutput("replay_score", 32'(bus.score_bcd), 32'h0001);
        checkOutput("model_best", 32'(toBcd(mBest)), 32'h0003);

        // Score and collision on the same edge.
        startGame();
        applyStimulus(1'b1, 20, pipe(5, 30, 10), 1);
        applyStimulus(1'b1, 20, pipe(0, 35, 25), 1);
        checkOutput("simul_dead", 32'(bus.state), 32'd3);
        checkOutput("simul_no_inc", 32'(bus.score_inc), 32'd0);
        checkOutput("simul_score", 32'(bus.score_bcd), 32'h0000);

        // Saturation at 9999.
        startGame();
        scorePoints(9999);
        checkOutput("score_9999", 32'(bus.score_bcd), 32'h9999);
        scorePoints(1);
        checkOutput("sat_inc", 32'(bus.score_inc), 32'd1);
        checkOutput("sat_hold", 32'(bus.score_bcd), 32'h9999);

        // Random play.
        startGame();
        repeat (3000) begin
            rst_n        = ($urandom_range(0, 299) != 0);
            bus.n_row    = 8'($urandom_range(30, 50));
            for (int k = 1; k < 3; k++) begin
                mn = $urandom_range(0, 20);
                bus.pipes[24*k +: 24] = pipe($urandom_range(0, 12), mn + $urandom_range(1, 30), mn);
            end
            mn = $urandom_range(0, 20);
            applyStimulus($urandom_range(0, 39) != 0,
                          ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(5, 35),
                          pipe(($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 200),
                               mn + $urandom_range(5, 30), mn),
                          1);
        end

        compareOn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
